// File: rtl/mem_access_ctrl.sv
// Load/store access controller: one valid/ready bus transaction per request, load extraction and error reporting.
// Optional bus-wait timeout enabled by defining MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [2:0]  req_funct3,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_off;
  logic [2:0]  r_funct3;
  logic        r_mem_valid;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic        w_reject;
  logic [31:0] w_load_data;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  r_cnt;
`endif

  // Misaligned halfword/word, reserved funct3 encodings, and unsigned-size stores are all rejected.
  function automatic logic f_access_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic err;
    case (f3)
      3'b000:  err = 1'b0;
      3'b001:  err = off[0];
      3'b010:  err = |off;
      3'b100:  err = we;
      3'b101:  err = we | off[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [31:0] f_extract(input logic [31:0] rdata, input logic [1:0] off,
                                            input logic [2:0] f3);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    shifted = rdata >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'd0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'd0, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

  assign w_reject    = f_access_err(req_we, req_funct3, req_addr[1:0]);
  assign w_load_data = r_mem_we ? 32'd0 : f_extract(mem_rdata, r_off, r_funct3);

  // Access FSM with all response and bus outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_off        <= 2'd0;
      r_funct3     <= 3'd0;
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_wstrb  <= 4'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_cnt        <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_resp_valid <= 1'b0;
          if (req_valid) begin
            r_off    <= req_addr[1:0];
            r_funct3 <= req_funct3;
            if (w_reject) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
              r_state      <= S_DONE;
            end else begin
              r_mem_valid <= 1'b1;
              r_mem_we    <= req_we;
              r_mem_addr  <= {req_addr[31:2], 2'b00};
              r_mem_wdata <= req_wdata;
              r_mem_wstrb <= req_we ? req_wstrb : 4'b0000;
`ifdef MEM_TIMEOUT_EN
              r_cnt       <= 8'd0;
`endif
              r_state     <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            r_mem_valid  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_load_data;
            r_state      <= S_DONE;
`ifdef MEM_TIMEOUT_EN
          end else if (r_cnt == LP_TO_LAST) begin
            r_mem_valid  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= 32'd0;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
`else
          end else begin
            r_state <= S_BUSY;
`endif
          end
        end
        S_DONE: begin
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_mem_valid  <= 1'b0;
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  // Combinational so the pipeline advances on the edge that leaves DONE.
  assign stall      = ((r_state == S_IDLE) && req_valid) || (r_state == S_BUSY);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_valid  = r_mem_valid;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wstrb  = r_mem_wstrb;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized and directed bench for mem_access_ctrl against a transaction-level reference model.
// Define MEM_TIMEOUT_EN to build both DUT and model with a 4-cycle bus timeout.
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int DUT_TO = 4;
  localparam int TO_LIM = 4;
`else
  localparam int DUT_TO = 64;
  localparam int TO_LIM = 1000000;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_funct3;
  logic        stall, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  mem_access_ctrl #(.TIMEOUT_CYCLES(DUT_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_funct3(req_funct3),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  logic        chk_en = 1'b0;
  logic        e_stall, e_mv, e_rv, e_err, e_we;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_wstrb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference rules: size from funct3[1:0], natural alignment, unsigned stores illegal.
  function automatic logic m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
    if (we && f3 > 3'b010) return 1'b0;
    sz = 1 << f3[1:0];
    return (int'(a[1:0]) % sz) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] v, mask;
    int nb;
    nb = (f3[1:0] == 2'd0) ? 8 : ((f3[1:0] == 2'd1) ? 16 : 32);
    if (nb == 32) return w;
    mask = (32'd1 << nb) - 32'd1;
    v = (w >> (8 * int'(off))) & mask;
    if (!f3[2] && v[nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Single per-cycle compare of DUT outputs against the current expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("mem_valid", {31'd0, mem_valid}, {31'd0, e_mv});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, e_rv});
      if (e_mv) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e_wstrb});
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_rv) begin
        chk("resp_rdata", resp_rdata, e_rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e_err});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic s, input logic mv, input logic rv);
    e_stall = s; e_mv = mv; e_rv = rv;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0; req_addr = $urandom; req_funct3 = 3'($urandom);
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    set_exp(1'b0, 1'b0, 1'b0);
    next_cycle();
  endtask

  // One request: d cycles without mem_ready before the accepting cycle; brd is the returned word.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [2:0] f3, input int d,
                         input logic [31:0] brd, input logic use_lit, input logic [31:0] lit);
    logic ok, tmo;
    int busy;
    logic [31:0] rd;
    ok   = m_legal(we, f3, addr);
    tmo  = (d + 1) > TO_LIM;
    busy = tmo ? TO_LIM : d + 1;
    rd   = we ? 32'd0 : m_load(brd, f3, addr[1:0]);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_wstrb = wstrb; req_funct3 = f3;
    e_addr = {addr[31:2], 2'b00}; e_we = we; e_wdata = wdata; e_wstrb = we ? wstrb : 4'b0000;
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    set_exp(1'b1, 1'b0, 1'b0);
    next_cycle();
    if (ok) begin
      for (int k = 1; k <= busy; k++) begin
        mem_ready = (!tmo && k == d + 1);
        mem_rdata = mem_ready ? brd : $urandom;
        set_exp(1'b1, 1'b1, 1'b0);
        next_cycle();
      end
    end
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    e_err   = !ok || tmo;
    e_rdata = e_err ? 32'd0 : rd;
    set_exp(1'b0, 1'b0, 1'b1);
    if (use_lit) begin
      @(negedge clk);
      chk("lit_rdata", resp_rdata, lit);
    end
    next_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_wstrb = 4'd0; req_funct3 = 3'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    e_err = 1'b0; e_we = 1'b0; e_addr = 32'd0; e_wdata = 32'd0; e_rdata = 32'd0; e_wstrb = 4'd0;
    set_exp(1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    chk_en = 1'b1;
    idle_cycle();

    run_txn(1'b0, 32'h100, 32'h0, 4'h0, 3'b010, 0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    run_txn(1'b0, 32'h103, 32'h0, 4'h0, 3'b000, 0, 32'h80FF1234, 1'b1, 32'hFFFFFF80);
    run_txn(1'b0, 32'h103, 32'h0, 4'h0, 3'b100, 1, 32'h80FF1234, 1'b1, 32'h00000080);
    run_txn(1'b0, 32'h102, 32'h0, 4'h0, 3'b001, 0, 32'h80FF1234, 1'b1, 32'hFFFF80FF);
    run_txn(1'b1, 32'h102, 32'hABCDABCD, 4'b1100, 3'b001, 3, 32'h12345678, 1'b1, 32'h0);
    run_txn(1'b1, 32'h102, 32'h11111111, 4'hF, 3'b010, 0, 32'h0, 1'b1, 32'h0);
    run_txn(1'b0, 32'h101, 32'h0, 4'h0, 3'b001, 0, 32'hFFFFFFFF, 1'b1, 32'h0);
    run_txn(1'b0, 32'h100, 32'h0, 4'h0, 3'b011, 0, 32'hFFFFFFFF, 1'b1, 32'h0);
    idle_cycle();
    run_txn(1'b0, 32'h200, 32'h0, 4'h0, 3'b010, 10, 32'hCAFEF00D, 1'b0, 32'h0);
    run_txn(1'b0, 32'h204, 32'h0, 4'h0, 3'b010, 3, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5);

    // Reset pulse in the middle of a long BUSY phase.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300; req_funct3 = 3'b010;
    e_addr = 32'h300; e_we = 1'b0; e_wstrb = 4'd0; mem_ready = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);
    next_cycle();
    set_exp(1'b1, 1'b1, 1'b0);
    next_cycle();
    next_cycle();
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("rstmid_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rstmid_stall", {31'd0, stall}, 32'd0);
    chk("rstmid_resp_valid", {31'd0, resp_valid}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) idle_cycle();
    run_txn(1'b0, 32'h300, 32'h0, 4'h0, 3'b010, 0, 32'h01234567, 1'b1, 32'h01234567);

    for (int i = 0; i < 300; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
              int'($urandom_range(0, 6)), $urandom, 1'b0, 32'h0);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) idle_cycle();
    end
    idle_cycle();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
